// File: rtl/uut_seq_if.sv
// uut_seq_if: control-unit side of the UUT run sequencer (start/abort request, busy/done/result).
// Macro UUT_SEQ_MINMAX_EN adds stats_clr and the cycles_min/cycles_max result pair.
interface uut_seq_if #(parameter int CYCLE_W = 32) ();
    logic               start;
    logic               abort;
    logic [1:0]         clk_sel_req;
    logic               busy;
    logic               done;
    logic [CYCLE_W-1:0] cycles;
    logic [1:0]         status;
`ifdef UUT_SEQ_MINMAX_EN
    logic               stats_clr;
    logic [CYCLE_W-1:0] cycles_min;
    logic [CYCLE_W-1:0] cycles_max;
    modport master (output start, abort, clk_sel_req, stats_clr,
                    input busy, done, cycles, status, cycles_min, cycles_max);
    modport slave  (input start, abort, clk_sel_req, stats_clr,
                    output busy, done, cycles, status, cycles_min, cycles_max);
`else
    modport master (output start, abort, clk_sel_req,
                    input busy, done, cycles, status);
    modport slave  (input start, abort, clk_sel_req,
                    output busy, done, cycles, status);
`endif
endinterface

// File: rtl/uut_run_sequencer.sv
// uut_run_sequencer: selects UUT clock, settles, pulses UUT reset, then counts run cycles to end/error/timeout.
// Macro UUT_SEQ_MINMAX_EN adds min/max tracking of ok run lengths with stats_clr.
module uut_run_sequencer #(
    parameter int CYCLE_W        = 32,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int RST_CYCLES     = 16,
    parameter int SETTLE_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    uut_seq_if.slave   ctl,
    output logic [1:0] clk_uut_sel,
    output logic       rst_uut,
    input  logic       end_uut,
    input  logic       err_uut
);
    typedef enum logic [2:0] {IDLE, SEL_CLK, RESET, RUN, DONE} state_t;
    localparam logic [CYCLE_W-1:0] SETTLE_LAST = CYCLE_W'(SETTLE_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] RST_LAST    = CYCLE_W'(RST_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] TO_LAST     = CYCLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] TO_VAL      = CYCLE_W'(TIMEOUT_CYCLES);
    localparam logic [1:0] ST_OK = 2'b00, ST_ERR = 2'b01, ST_TO = 2'b10, ST_ABORT = 2'b11;

    state_t             state_q, state_d;
    logic [CYCLE_W-1:0] cnt_q, cnt_d, cycles_q, cycles_d;
    logic [1:0]         sel_q, sel_d, status_q, status_d;
    logic [1:0]         end_sync_q, end_sync_d, err_sync_q, err_sync_d;
    logic               end_s, err_s;

    assign end_s = end_sync_q[1];
    assign err_s = err_sync_q[1];

    // cnt_q doubles as the settle/reset timer before RUN and as the run counter in RUN
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        cycles_d   = cycles_q;
        status_d   = status_q;
        end_sync_d = {end_sync_q[0], end_uut};
        err_sync_d = {err_sync_q[0], err_uut};
        case (state_q)
            IDLE: if (ctl.start) begin
                state_d = SEL_CLK;
                sel_d   = (ctl.clk_sel_req == 2'b11) ? 2'b00 : ctl.clk_sel_req;
                cnt_d   = '0;
            end
            SEL_CLK: begin
                cnt_d   = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == SETTLE_LAST) ? RESET : SEL_CLK;
            end
            RESET: begin
                cnt_d   = (cnt_q == RST_LAST) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == RST_LAST) ? RUN : RESET;
            end
            RUN: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (err_s || end_s || cnt_q == TO_LAST) begin
                    state_d  = DONE;
                    cycles_d = (err_s || end_s) ? cnt_q : TO_VAL;
                    status_d = err_s ? ST_ERR : end_s ? ST_OK : ST_TO;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        if (ctl.abort && (state_q == SEL_CLK || state_q == RESET || state_q == RUN)) begin
            state_d  = DONE;
            cycles_d = (state_q == RUN) ? cnt_q : '0;
            status_d = ST_ABORT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= 2'b00;
            cycles_q   <= '0;
            status_q   <= ST_OK;
            end_sync_q <= 2'b00;
            err_sync_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            cycles_q   <= cycles_d;
            status_q   <= status_d;
            end_sync_q <= end_sync_d;
            err_sync_q <= err_sync_d;
        end
    end

`ifdef UUT_SEQ_MINMAX_EN
    logic [CYCLE_W-1:0] min_q, min_d, max_q, max_d;
    logic               ok_done;

    assign ok_done = (state_q == DONE) && (status_q == ST_OK);

    always_comb begin
        min_d = ctl.stats_clr ? '1 : (ok_done && cycles_q < min_q) ? cycles_q : min_q;
        max_d = ctl.stats_clr ? '0 : (ok_done && cycles_q > max_q) ? cycles_q : max_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign ctl.cycles_min = min_q;
    assign ctl.cycles_max = max_q;
`endif

    assign clk_uut_sel = sel_q;
    assign rst_uut     = (state_q != RUN);
    assign ctl.busy    = (state_q != IDLE);
    assign ctl.done    = (state_q == DONE);
    assign ctl.cycles  = cycles_q;
    assign ctl.status  = status_q;
endmodule

// File: tb/tb_uut_run_sequencer.sv
// tb_uut_run_sequencer: randomized runs against an event-time reference model, checked by a done-driven scoreboard.
// Covers min/max statistics when UUT_SEQ_MINMAX_EN is defined.
module tb_uut_run_sequencer;
    localparam int NONE = 100000;
    localparam int TO   = 100;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] cyc;
        logic [1:0]  st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  clk_uut_sel;
    logic        rst_uut;
    logic        end_uut = 1'b0;
    logic        err_uut = 1'b0;
    int          total = 0;
    int          bad = 0;
    exp_t        q[$];
    bit          chk_after = 0;
    logic [31:0] mn = 32'hFFFF_FFFF;
    logic [31:0] mx = 32'h0;

    uut_seq_if #(.CYCLE_W(32)) bus ();

    uut_run_sequencer #(
        .CYCLE_W(32), .TIMEOUT_CYCLES(TO), .RST_CYCLES(4), .SETTLE_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .ctl(bus), .clk_uut_sel(clk_uut_sel),
        .rst_uut(rst_uut), .end_uut(end_uut), .err_uut(err_uut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // an input raised at RUN cycle d is seen by the counter two cycles later
    function automatic int det(input int d);
        if (d == NONE) return NONE;
        return (d + 2 < 0) ? 0 : d + 2;
    endfunction

    function automatic exp_t model(input logic [1:0] req, input bit pre_ab, input int end_d,
                                   input int err_d, input int ab_a);
        exp_t e;
        int te, tr, first;
        e.sel = (req == 2'b11) ? 2'b00 : req;
        te = det(end_d);
        tr = det(err_d);
        first = TO - 1;
        if (te < first) first = te;
        if (tr < first) first = tr;
        if (ab_a < first) first = ab_a;
        if (pre_ab) begin e.cyc = 0; e.st = 2'b11; end
        else if (ab_a == first) begin e.cyc = ab_a; e.st = 2'b11; end
        else if (tr == first) begin e.cyc = tr; e.st = 2'b01; end
        else if (te == first) begin e.cyc = te; e.st = 2'b00; end
        else begin e.cyc = TO; e.st = 2'b10; end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (chk_after) begin
            chk_after = 0;
            chk("busy_after_done", {30'd0, bus.busy, bus.done}, 0);
        end
        if (rst && bus.done) begin
            chk_after = 1;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got cycles=%0d status=%0d want no done", bus.cycles, bus.status);
            end else begin
                e = q.pop_front();
                chk("cycles", bus.cycles, e.cyc);
                chk("status", {30'd0, bus.status}, {30'd0, e.st});
                chk("clk_uut_sel", {30'd0, clk_uut_sel}, {30'd0, e.sel});
                chk("rst_uut_in_done", {31'd0, rst_uut}, 1);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 200) begin step(); n++; end
        if (bus.busy) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got busy=1 want 0 within 200 cycles");
        end
    endtask

    task automatic run(input logic [1:0] req, input int pre_ab, input int end_d,
                       input int err_d, input int ab_a, input bit xs);
        exp_t e;
        int n;
        bit got;
        wait_idle();
        e = model(req, pre_ab >= 0, end_d, err_d, ab_a);
        if (e.st == 2'b00) begin
            if (e.cyc < mn) mn = e.cyc;
            if (e.cyc > mx) mx = e.cyc;
        end
        q.push_back(e);
        if (end_d < 0) end_uut = 1'b1;
        bus.start = 1'b1;
        bus.clk_sel_req = req;
        step();
        bus.start = 1'b0;
        if (pre_ab >= 0) begin
            repeat (pre_ab) step();
            bus.abort = 1'b1;
            step();
            bus.abort = 1'b0;
            chk("abort_done_next", {31'd0, bus.done}, 1);
        end else begin
            n = 0;
            while (rst_uut && n < 20) begin step(); n++; end
            chk("rst_uut_fall_lat", n, 6);
            got = 0;
            for (int k = 0; k < 130 && !got; k++) begin
                if (k == end_d) end_uut = 1'b1;
                if (k == err_d) err_uut = 1'b1;
                if (k == ab_a) bus.abort = 1'b1;
                if (xs && k == 3) bus.start = 1'b1;
                step();
                bus.abort = 1'b0;
                bus.start = 1'b0;
                got = bus.done;
            end
            if (!got) begin
                total++;
                bad++;
                $display("FAIL run_done: got no done want done within 130 run cycles");
            end
        end
        end_uut = 1'b0;
        err_uut = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.clk_sel_req = 2'b00;
`ifdef UUT_SEQ_MINMAX_EN
        bus.stats_clr = 1'b0;
`endif
        step();
        step();
        chk("reset_rst_uut", {31'd0, rst_uut}, 1);
        chk("reset_busy", {31'd0, bus.busy}, 0);
        chk("reset_done", {31'd0, bus.done}, 0);
        chk("reset_cycles", bus.cycles, 0);
        chk("reset_status", {30'd0, bus.status}, 0);
        chk("reset_sel", {30'd0, clk_uut_sel}, 0);
        rst = 1'b1;
        step();
        run(2'b10, -1, 10, NONE, NONE, 0);
        run(2'b00, -1, 5, 5, NONE, 0);
        run(2'b01, -1, NONE, NONE, NONE, 0);
        run(2'b01, 3, NONE, NONE, NONE, 0);
        run(2'b11, 0, NONE, NONE, NONE, 0);
        run(2'b01, -1, 20, NONE, NONE, 1);
        run(2'b10, -1, 30, NONE, 7, 0);
        run(2'b10, -1, 5, NONE, 7, 0);
        run(2'b00, -1, -6, NONE, NONE, 0);
        for (int i = 0; i < 20; i++) begin
            int mode, ed, rd, ad;
            mode = $urandom_range(0, 9);
            ed = $urandom_range(0, 60);
            rd = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : NONE;
            ad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : NONE;
            if (mode == 0) run(2'($urandom_range(0, 3)), $urandom_range(0, 5), NONE, NONE, NONE, 0);
            else if (mode == 1) run(2'($urandom_range(0, 3)), -1, NONE, NONE, NONE, 0);
            else run(2'($urandom_range(0, 3)), -1, ed, rd, ad, 1'($urandom_range(0, 1)));
        end
        run(2'b10, -1, 10, NONE, NONE, 0);
        wait_idle();
        bus.start = 1'b1;
        bus.clk_sel_req = 2'b11;
        step();
        bus.start = 1'b0;
        repeat (12) step();
        chk("sel_norm_11", {30'd0, clk_uut_sel}, 0);
        chk("mid_run_rst_uut", {31'd0, rst_uut}, 0);
        rst = 1'b0;
        #1;
        chk("async_rst_uut", {31'd0, rst_uut}, 1);
        chk("async_busy", {31'd0, bus.busy}, 0);
        chk("async_cycles", bus.cycles, 0);
        chk("async_status", {30'd0, bus.status}, 0);
        mn = 32'hFFFF_FFFF;
        mx = 32'h0;
        step();
        step();
        rst = 1'b1;
        step();
`ifdef UUT_SEQ_MINMAX_EN
        chk("mm_reset_min", bus.cycles_min, 32'hFFFF_FFFF);
        chk("mm_reset_max", bus.cycles_max, 0);
        run(2'b00, -1, 10, NONE, NONE, 0);
        run(2'b01, -1, 28, NONE, NONE, 0);
        run(2'b10, -1, 6, NONE, NONE, 0);
        run(2'b10, -1, NONE, 3, NONE, 0);
        step();
        chk("mm_min", bus.cycles_min, mn);
        chk("mm_max", bus.cycles_max, mx);
        bus.stats_clr = 1'b1;
        step();
        bus.stats_clr = 1'b0;
        chk("mm_clr_min", bus.cycles_min, 32'hFFFF_FFFF);
        chk("mm_clr_max", bus.cycles_max, 0);
`endif
        repeat (3) step();
        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
